// File: rtl/data_mem_responder.sv
// Purpose: multi-cycle data-memory responder that services one load/store at a time from a local word array.
// Latency: the response is valid LATENCY cycles after the request handshake cycle.
// Backpressure: one transaction outstanding; req_ready is low outside IDLE, and RESP holds until resp_ready.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INI = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept;
   logic          commit;
   logic          c_write;
   logic [31:0]   c_addr;
   logic [31:0]   c_wdata;
   logic          c_err;
   logic [AW-1:0] c_idx;

   assign accept = req_valid && (state_q == IDLE);

   // With LATENCY == 1 the access commits on the acceptance edge, so the
   // commit path must see the live request rather than the latched copy.
   assign commit  = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));
   assign c_write = (state_q == IDLE) ? req_write : write_q;
   assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   // Range check uses the full 30-bit word index, so high addresses never alias.
   assign c_err   = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DEPTH_L);
   assign c_idx   = c_addr[AW+1:2];

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Control FSM: request capture, latency countdown, response hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (commit) begin
            rdata_q <= (c_err || c_write) ? 32'd0 : mem_q[c_idx];
            err_q   <= c_err;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INI;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q <= IDLE;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Word storage: cleared by reset, written only by a committed, error-free store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (commit && c_write && !c_err) begin
         mem_q[c_idx] <= c_wdata;
      end
   end

endmodule
